// File: rtl/rbm_vote_controller_if.sv
// Handshake and result bundle for the RBM vote controller: run request and
// configuration, the classify-layer sample handshake, and the result outputs.
interface rbm_vote_controller_if #(
  parameter int OUTPUT_DIM  = 10,
  parameter int COUNT_WIDTH = 12,
  parameter int ITER_WIDTH  = 16,
  parameter int INDEX_WIDTH = 4
);
  logic                              start;
  logic [ITER_WIDTH-1:0]             iteration_num;
  logic                              early_stop_en;
  logic [COUNT_WIDTH-1:0]            margin;
  logic                              layer_finish;
  logic [OUTPUT_DIM-1:0]             sample;
  logic                              layer_reset;
  logic                              busy;
  logic                              done;
  logic                              early_stopped;
  logic [OUTPUT_DIM*COUNT_WIDTH-1:0] counts;
  logic [INDEX_WIDTH-1:0]            winner;
  logic [COUNT_WIDTH-1:0]            winner_count;
  logic [ITER_WIDTH-1:0]             iterations_done;

  // Requester / layer side: drives the run request and samples.
  modport master (
    output start, iteration_num, early_stop_en, margin, layer_finish, sample,
    input  layer_reset, busy, done, early_stopped, counts, winner,
           winner_count, iterations_done
  );

  // Controller side.
  modport slave (
    input  start, iteration_num, early_stop_en, margin, layer_finish, sample,
    output layer_reset, busy, done, early_stopped, counts, winner,
           winner_count, iterations_done
  );
endinterface

// File: rtl/rbm_vote_controller.sv
// Iteration controller and vote accumulator for the stochastic RBM classifier.
// Each iteration restarts the layer chain, waits for a classify-layer sample,
// adds it into per-class saturating counters, then runs a one-class-per-cycle
// argmax scan that also decides whether the run is finished (iteration limit
// reached, or the winner leads the runner-up by at least the margin).
module rbm_vote_controller #(
  parameter int OUTPUT_DIM  = 10,
  parameter int COUNT_WIDTH = 12,
  parameter int ITER_WIDTH  = 16,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  rbm_vote_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_WAIT,
    S_ACCUM,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(OUTPUT_DIM - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_layer_reset;

  // Run configuration captured when a start is accepted.
  logic [ITER_WIDTH-1:0]   r_iter_limit;
  logic                    r_es_en;
  logic [COUNT_WIDTH-1:0]  r_margin;
  logic [OUTPUT_DIM-1:0]   r_sample;

  // Results.
  logic [COUNT_WIDTH-1:0]  r_cnt [OUTPUT_DIM];
  logic [ITER_WIDTH-1:0]   r_iter_done;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_early;
  logic [INDEX_WIDTH-1:0]  r_winner;
  logic [COUNT_WIDTH-1:0]  r_winner_count;

  // Argmax scan state.
  logic [INDEX_WIDTH-1:0]  r_scan_idx;
  logic [COUNT_WIDTH-1:0]  r_best_val;
  logic [COUNT_WIDTH-1:0]  r_second_val;
  logic [INDEX_WIDTH-1:0]  r_best_idx;

  logic                    w_accept;
  logic                    w_scan_last;
  logic [COUNT_WIDTH-1:0]  w_scan_val;
  logic [COUNT_WIDTH-1:0]  w_base_best;
  logic [COUNT_WIDTH-1:0]  w_base_second;
  logic [INDEX_WIDTH-1:0]  w_base_idx;
  logic [COUNT_WIDTH-1:0]  w_new_best;
  logic [COUNT_WIDTH-1:0]  w_new_second;
  logic [INDEX_WIDTH-1:0]  w_new_idx;
  logic [COUNT_WIDTH-1:0]  w_lead;
  logic                    w_hit_limit;
  logic                    w_stop;

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(
    input logic [COUNT_WIDTH-1:0] v,
    input logic                   en
  );
    if (en && (v != CNT_MAX)) return v + COUNT_WIDTH'(1);
    return v;
  endfunction

  assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_scan_last = (r_scan_idx == LAST_IDX);
  assign w_scan_val  = r_cnt[r_scan_idx];

  // The first scan cycle starts from an empty best/second pair.
  assign w_base_best   = (r_scan_idx == '0) ? '0 : r_best_val;
  assign w_base_second = (r_scan_idx == '0) ? '0 : r_second_val;
  assign w_base_idx    = (r_scan_idx == '0) ? '0 : r_best_idx;

  // One scan step: strictly greater takes the lead (lowest index wins ties);
  // anything above the runner-up, including a tie with the leader, becomes
  // the new runner-up.
  always_comb begin
    w_new_best   = w_base_best;
    w_new_second = w_base_second;
    w_new_idx    = w_base_idx;
    if (w_scan_val > w_base_best) begin
      w_new_best   = w_scan_val;
      w_new_second = w_base_best;
      w_new_idx    = r_scan_idx;
    end else if (w_scan_val > w_base_second) begin
      w_new_second = w_scan_val;
    end
  end

  // best >= second is an invariant of the scan, so the lead never underflows.
  assign w_lead      = w_new_best - w_new_second;
  assign w_hit_limit = (r_iter_done == r_iter_limit);
  assign w_stop      = w_hit_limit || (r_es_en && (w_lead >= r_margin));

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state decode and layer-chain restart control.
  always_comb begin
    w_next_state  = r_state;
    w_layer_reset = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_next_state = (bus.iteration_num == '0) ? S_DONE : S_RESTART;
      end
      S_RESTART: w_next_state = S_WAIT;
      S_WAIT: begin
        w_layer_reset = 1'b0;
        if (bus.layer_finish) w_next_state = S_ACCUM;
      end
      S_ACCUM: begin
        w_layer_reset = 1'b0;
        w_next_state  = S_SCAN;
      end
      S_SCAN: begin
        w_layer_reset = 1'b0;
        if (w_scan_last) w_next_state = w_stop ? S_DONE : S_RESTART;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Vote counters, iteration count, status flags and registered result.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < OUTPUT_DIM; i++) r_cnt[i] <= '0;
      r_iter_done    <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_early        <= 1'b0;
      r_winner       <= '0;
      r_winner_count <= '0;
      r_scan_idx     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            for (int i = 0; i < OUTPUT_DIM; i++) r_cnt[i] <= '0;
            r_iter_done    <= '0;
            r_early        <= 1'b0;
            r_winner       <= '0;
            r_winner_count <= '0;
            // A zero-iteration run completes on the accepting edge.
            if (bus.iteration_num == '0) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_busy <= 1'b1;
              r_done <= 1'b0;
            end
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < OUTPUT_DIM; i++) r_cnt[i] <= sat_inc(r_cnt[i], r_sample[i]);
          r_iter_done <= r_iter_done + ITER_WIDTH'(1);
          r_scan_idx  <= '0;
        end
        S_SCAN: begin
          r_scan_idx <= r_scan_idx + INDEX_WIDTH'(1);
          if (w_scan_last) begin
            r_winner       <= w_new_idx;
            r_winner_count <= w_new_best;
            if (w_stop) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_early <= !w_hit_limit;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Run configuration, captured sample and running best/second (no reset needed).
  always_ff @(posedge i_clock) begin
    if (w_accept) begin
      r_iter_limit <= bus.iteration_num;
      r_es_en      <= bus.early_stop_en;
      r_margin     <= bus.margin;
    end
    if ((r_state == S_WAIT) && bus.layer_finish) r_sample <= bus.sample;
    if (r_state == S_SCAN) begin
      r_best_val   <= w_new_best;
      r_second_val <= w_new_second;
      r_best_idx   <= w_new_idx;
    end
  end

  for (genvar g = 0; g < OUTPUT_DIM; g++) begin : g_counts
    assign bus.counts[g*COUNT_WIDTH +: COUNT_WIDTH] = r_cnt[g];
  end

  assign bus.layer_reset     = w_layer_reset;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.early_stopped   = r_early;
  assign bus.winner          = r_winner;
  assign bus.winner_count    = r_winner_count;
  assign bus.iterations_done = r_iter_done;

endmodule
